// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Serial UART transmitter. 8 data bits sent LSB first, optional
//            even/odd parity bit, 1 or 2 stop bits. One byte is accepted per
//            tx_send/tx_busy handshake, and uart_txd is driven from a register.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  // Bit period in clocks, rounded to nearest (must come out >= 2).
  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + (BAUD_RATE / 2)) / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Terminal values for the baud counter and the stop-bit index.
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             PAR_INV   = (PARITY_ODD != 0);
  localparam logic             PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             tx_busy_q;
  logic             tx_done_q;
  logic             txd_q;

  // End of the current bit period; the next bit is driven on this edge.
  logic             bit_end;
  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // Frame sequencer: every output is a register so the pin never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      // tx_done is a single-cycle strobe unless re-asserted below.
      tx_done_q <= 1'b0;

      if (state_q == S_IDLE) begin
        baud_cnt_q <= '0;
        if (tx_send) begin
          // Accept: latch the byte and its parity, start bit goes out now,
          // busy rises on the same edge so the sender never sees a false idle.
          shift_q   <= tx_data;
          parity_q  <= (^tx_data) ^ PAR_INV;
          tx_busy_q <= 1'b1;
          txd_q     <= 1'b0;
          state_q   <= S_START;
        end
      end else if (!bit_end) begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end else begin
        baud_cnt_q <= '0;
        case (state_q)
          S_START: begin
            txd_q     <= shift_q[0];
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
              stop_idx_q <= 1'b0;
              if (PAR_ON) begin
                txd_q   <= parity_q;
                state_q <= S_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          S_PARITY: begin
            txd_q      <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= S_STOP;
          end
          S_STOP: begin
            if (stop_idx_q == STOP_LAST) begin
              // Line stays high; the next accept may happen on the very next edge.
              tx_busy_q <= 1'b0;
              tx_done_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
          default: begin
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign uart_txd = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx. Four instances (8N1, 8E1, 8O1,
//            8N2) at 4 clocks per bit; a line decoder per instance pops and
//            compares expected frames queued by the stimulus process.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] data [4];
  logic       send [4];
  logic       busy [4];
  logic       done [4];
  logic       txd  [4];

  exp_t exp_q [4][$];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int PEN   = (k == 1 || k == 2) ? 1 : 0;
    localparam int POD   = (k == 2) ? 1 : 0;
    localparam int SB    = (k == 3) ? 2 : 1;
    localparam int NBITS = 10 + PEN + SB - 1;
    localparam int FRAME = CPB * NBITS;

    uart_tx #(
      .CLK_FREQ_HZ(460_800),
      .BAUD_RATE  (115_200),
      .PARITY_EN  (PEN),
      .PARITY_ODD (POD),
      .STOP_BITS  (SB)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (data[k]),
      .tx_send (send[k]),
      .tx_busy (busy[k]),
      .tx_done (done[k]),
      .uart_txd(txd[k])
    );

    // Line decoder: samples each bit mid-period and checks the whole frame.
    initial begin : mon
      logic [11:0] bits;
      logic [11:0] want;
      logic        ab;
      logic        bz_ok;
      logic        mis;
      exp_t        e;
      forever begin
        @(negedge clk);
        if (rst === 1'b0 && txd[k] === 1'b0) begin
          ab    = 1'b0;
          bz_ok = 1'b1;
          bits  = '0;
          for (int c = 0; c < FRAME; c++) begin
            if (c != 0) @(negedge clk);
            if (rst !== 1'b0) begin
              ab = 1'b1;
              break;
            end
            if (busy[k] !== 1'b1 || done[k] !== 1'b0) bz_ok = 1'b0;
            if (c % CPB == 2) bits[c / CPB] = txd[k];
          end
          if (!ab) begin
            @(negedge clk);
            total++;
            if (exp_q[k].size() == 0) begin
              bad++;
              $display("FAIL frame dut%0d: unexpected frame bits=%b want none", k, bits);
            end else begin
              e    = exp_q[k].pop_front();
              want = '1;
              want[0]   = 1'b0;
              want[8:1] = e.d;
              if (PEN != 0) want[9] = e.p;
              mis = 1'b0;
              for (int i = 0; i < NBITS; i++) if (bits[i] !== want[i]) mis = 1'b1;
              if (mis) begin
                bad++;
                $display("FAIL frame dut%0d: got bits %b want %b (byte %h)", k, bits, want, e.d);
              end
            end
            total++;
            if (!bz_ok) begin
              bad++;
              $display("FAIL busy_len dut%0d: busy/done wrong inside %0d-cycle frame, want busy=1 done=0", k, FRAME);
            end
            total++;
            if (busy[k] !== 1'b0 || done[k] !== 1'b1) begin
              bad++;
              $display("FAIL frame_end dut%0d: got busy=%b done=%b want busy=0 done=1", k, busy[k], done[k]);
            end
          end
        end
      end
    end
  end

  // Issue one byte at the current negedge and confirm busy rises immediately.
  task automatic send_byte(input int k, input logic [7:0] d, input logic p);
    exp_q[k].push_back('{d: d, p: p});
    data[k] = d;
    send[k] = 1'b1;
    @(negedge clk);
    send[k] = 1'b0;
    total++;
    if (busy[k] !== 1'b1) begin
      bad++;
      $display("FAIL accept dut%0d: busy=%b after send of %h, want 1", k, busy[k], d);
    end
  endtask

  // Wait (bounded) for busy to drop; returns on the negedge where it is low.
  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy[k] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy[k] !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout dut%0d: busy=%b after %0d cycles want 0", k, busy[k], n);
    end
  endtask

  initial begin : stim
    string s;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data[k] = 8'h00;
      send[k] = 1'b0;
    end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    for (int k = 0; k < 4; k++) begin
      total++;
      if (txd[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d: got txd=%b busy=%b done=%b want 1 0 0", k, txd[k], busy[k], done[k]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x52 8N1.
    send_byte(0, 8'h52, 1'b0);
    wait_idle(0);
    repeat (3) @(negedge clk);

    // Mid-frame request with 0xFF ignored; data changes during frame ignored.
    exp_q[0].push_back('{d: 8'h00, p: 1'b0});
    data[0] = 8'h00;
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    repeat (9) @(negedge clk);
    data[0] = 8'hFF;
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    data[0] = 8'h11;
    wait_idle(0);
    repeat (50) @(negedge clk);

    // tx_send held high: re-accepted in the first idle cycle.
    exp_q[0].push_back('{d: 8'h5A, p: 1'b0});
    exp_q[0].push_back('{d: 8'h5A, p: 1'b0});
    data[0] = 8'h5A;
    send[0] = 1'b1;
    @(negedge clk);
    wait_idle(0);
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL held_send dut0: busy=%b want 1", busy[0]);
    end
    send[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);

    // Parity: even 0x07 -> 1, 0x52 -> 1; odd 0x07 -> 0, 0xFF -> 1.
    send_byte(1, 8'h07, 1'b1);
    wait_idle(1);
    send_byte(1, 8'h52, 1'b1);
    wait_idle(1);
    send_byte(2, 8'h07, 1'b0);
    wait_idle(2);
    send_byte(2, 8'hFF, 1'b1);
    wait_idle(2);

    // Two stop bits, back to back.
    send_byte(3, 8'hA5, 1'b0);
    wait_idle(3);
    send_byte(3, 8'h0F, 1'b0);
    wait_idle(3);
    repeat (3) @(negedge clk);

    // Asynchronous reset during data bit 3 abandons the frame.
    data[0] = 8'h3C;
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    repeat (16) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (txd[0] !== 1'b1 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_rst dut0: got txd=%b busy=%b want 1 0", txd[0], busy[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(0, 8'h3C, 1'b0);
    wait_idle(0);

    // Result-sender style stream: pulse send, wait for !busy, repeat.
    s = "RES:0000BEEF\r\n";
    for (int i = 0; i < s.len(); i++) begin
      send_byte(0, s[i], 1'b0);
      wait_idle(0);
    end

    repeat (60) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin
        bad++;
        $display("FAIL missing dut%0d: %0d frames never seen, want 0", k, exp_q[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
